// File: rtl/pkt_fifo_if.sv
// Handshake bundle between the router write side, pkt_fifo and the output channel.
// PKT_FIFO_ERR_EN adds the sticky ovf_err/udf_err flags.
interface pkt_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic              lfd_state;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              dout_hdr;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              pkt_busy;
`ifdef PKT_FIFO_ERR_EN
    logic              ovf_err;
    logic              udf_err;
`endif

    modport master (
        output wr_en, lfd_state, din, rd_en,
`ifdef PKT_FIFO_ERR_EN
        input  ovf_err, udf_err,
`endif
        input  dout, dout_hdr, dout_valid, full, empty, almost_full, pkt_busy
    );

    modport slave (
        input  wr_en, lfd_state, din, rd_en,
`ifdef PKT_FIFO_ERR_EN
        output ovf_err, udf_err,
`endif
        output dout, dout_hdr, dout_valid, full, empty, almost_full, pkt_busy
    );
endinterface

// File: rtl/pkt_fifo.sv
// Packet-aware synchronous FIFO: stores {header bit, data}, tracks remaining bytes of the
// packet being read. Define PKT_FIFO_ERR_EN to add sticky overflow/underflow flags.
module pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int LEN_LSB  = 2,
    parameter int LEN_W    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soft_rst,
    pkt_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       occupancy;
    logic              full_i;
    logic              empty_i;
    logic              run;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W:0]   rd_word;
    logic [LEN_W-1:0]  rd_len;
    logic [LEN_W:0]    rem;
    logic [DATA_W-1:0] dout_q;
    logic              dout_hdr_q;
    logic              dout_valid_q;
    logic              pkt_busy_q;

    assign occupancy = wr_ptr - rd_ptr;
    assign full_i    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_i   = (wr_ptr == rd_ptr);

    // Requests made while either reset is active are discarded.
    assign run    = rst && !soft_rst;
    assign wr_acc = run && bus.wr_en && !full_i;
    assign rd_acc = run && bus.rd_en && !empty_i;

    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign rd_len  = rd_word[LEN_LSB +: LEN_W];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.din};
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            dout_q       <= '0;
            dout_hdr_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            rem          <= '0;
            pkt_busy_q   <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + 1'b1;
                dout_q     <= rd_word[DATA_W-1:0];
                dout_hdr_q <= rd_word[DATA_W];
                // Header reload also restarts tracking if a packet was still open.
                if (rd_word[DATA_W]) begin
                    rem        <= {1'b0, rd_len} + (LEN_W+1)'(1);
                    pkt_busy_q <= 1'b1;
                end else if (pkt_busy_q) begin
                    rem <= rem - 1'b1;
                    if (rem == (LEN_W+1)'(1)) begin
                        pkt_busy_q <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef PKT_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk) begin
        if (!run) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_i) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd_en && empty_i) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`endif

    assign bus.dout        = dout_q;
    assign bus.dout_hdr    = dout_hdr_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.full        = full_i;
    assign bus.empty       = empty_i;
    assign bus.almost_full = (occupancy >= AF_CNT);
    assign bus.pkt_busy    = pkt_busy_q;
endmodule

// File: tb/tb_pkt_fifo.sv
// Scoreboard bench for pkt_fifo at default parameters; words are queued by a reference
// model on acceptance and compared when dout_valid appears.
module tb_pkt_fifo;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;

    logic clk = 1'b0;
    logic rst;
    logic soft_rst;

    pkt_fifo_if #(.DATA_W(8)) bus ();

    pkt_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .soft_rst (soft_rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [8:0] mq[$];
    logic [8:0] exp_q[$];
    logic [7:0] m_dout;
    logic       m_hdr;
    logic       m_busy;
    int         m_rem;
    logic       m_ovf;
    logic       m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic sr, input logic we, input logic lfd,
                         input logic [7:0] d, input logic re);
        logic       rd_exp;
        logic [8:0] w;
        rst           = r;
        soft_rst      = sr;
        bus.wr_en     = we;
        bus.lfd_state = lfd;
        bus.din       = d;
        bus.rd_en     = re;
        rd_exp        = 1'b0;
        if (!r || sr) begin
            mq.delete();
            exp_q.delete();
            m_dout = '0;
            m_hdr  = 1'b0;
            m_busy = 1'b0;
            m_rem  = 0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            if (we && mq.size() == DEPTH) m_ovf = 1'b1;
            if (re && mq.size() == 0)     m_udf = 1'b1;
            if (re && mq.size() > 0) begin
                exp_q.push_back(mq.pop_front());
                rd_exp = 1'b1;
            end
            if (we && mq.size() + (rd_exp ? 1 : 0) < DEPTH) mq.push_back({lfd, d});
        end
        @(posedge clk);
        #1;
        check("dout_valid", bus.dout_valid, rd_exp);
        if ((bus.dout_valid || rd_exp) && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            m_dout = w[7:0];
            m_hdr  = w[8];
            if (w[8]) begin
                m_rem  = int'(w[7:2]) + 1;
                m_busy = 1'b1;
            end else if (m_busy) begin
                m_rem--;
                if (m_rem == 0) m_busy = 1'b0;
            end
        end
        check("dout", bus.dout, m_dout);
        check("dout_hdr", bus.dout_hdr, m_hdr);
        check("pkt_busy", bus.pkt_busy, m_busy);
        check("empty", bus.empty, mq.size() == 0);
        check("full", bus.full, mq.size() == DEPTH);
        check("almost_full", bus.almost_full, mq.size() >= AF);
`ifdef PKT_FIFO_ERR_EN
        check("ovf_err", bus.ovf_err, m_ovf);
        check("udf_err", bus.udf_err, m_udf);
`endif
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        cycle(1'b1, 1'b0, 1'b1, lfd, d, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        // Reset with a write request pending: nothing may be stored.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
        check("rst_empty", bus.empty, 1);
        check("rst_dout", bus.dout, 0);

        // Fill to full, overflow, drain.
        for (int i = 0; i < DEPTH; i++) begin
            wr(8'(i), 1'b0);
            if (i == AF - 2) check("af_before_14", bus.almost_full, 0);
            if (i == AF - 1) check("af_at_14", bus.almost_full, 1);
        end
        check("full_at_16", bus.full, 1);
        wr(8'hAA, 1'b0);
        check("full_after_drop", bus.full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd();
            check("drain_order", bus.dout, i);
        end
        check("drained_empty", bus.empty, 1);
        rd();

        // Wrap-around rounds.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) wr(8'(8'h40 + r * 16 + i), 1'b0);
            for (int i = 0; i < 10; i++) rd();
        end

        // Simultaneous read/write at occupancy 5.
        for (int i = 0; i < 5; i++) wr(8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h90 + i), 1'b1);
            check("simul_oldest", bus.dout, 8'h80 + i);
        end
        for (int i = 0; i < 5; i++) rd();

        // Simultaneous read/write at full: write dropped.
        for (int i = 0; i < DEPTH; i++) wr(8'(8'hC0 + i), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1);
        check("full_rw_notfull", bus.full, 0);
        check("full_rw_af", bus.almost_full, 1);
        for (int i = 0; i < DEPTH - 1; i++) rd();
        check("full_rw_empty", bus.empty, 1);

        // Packet tracking: header len=3 plus 3 payload and 1 parity byte.
        wr(8'h0C, 1'b1);
        for (int i = 0; i < 4; i++) wr(8'(8'hE0 + i), 1'b0);
        rd();
        check("hdr_flag", bus.dout_hdr, 1);
        check("hdr_busy", bus.pkt_busy, 1);
        for (int i = 0; i < 3; i++) begin
            rd();
            check("pkt_mid_busy", bus.pkt_busy, 1);
        end
        rd();
        check("pkt_end_busy", bus.pkt_busy, 0);

        // Soft reset mid-packet, then a fresh packet (len=2).
        wr(8'h0C, 1'b1);
        for (int i = 0; i < 4; i++) wr(8'(8'hD0 + i), 1'b0);
        rd();
        rd();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1);
        check("srst_empty", bus.empty, 1);
        check("srst_busy", bus.pkt_busy, 0);
        wr(8'h08, 1'b1);
        for (int i = 0; i < 3; i++) wr(8'(8'hB0 + i), 1'b0);
        rd();
        check("hdr2_busy", bus.pkt_busy, 1);
        for (int i = 0; i < 3; i++) rd();
        check("pkt2_end_busy", bus.pkt_busy, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
